btn_conditioner: RTL and testbench
==================================

BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_BTN, default 3, number of push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz), consecutive stable cycles required to accept a level change; legal range 2 to 2^24-1.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn_raw  input  N_BTN  asynchronous board buttons, active-low (0 = pressed).
REQ-006 btn_clean  output  N_BTN  debounced level, active-low; feeds the unlock FSM button input directly.
REQ-007 btn_press  output  N_BTN  one-cycle active-high pulse per accepted press.
REQ-008 btn_release  output  N_BTN  one-cycle active-high pulse per accepted release.
REQ-009 multi_held  output  1  high while more than one btn_clean bit is low.

Function
REQ-010 Each btn_raw bit SHALL pass a 2-flop synchronizer before any other use.
REQ-011 Each channel SHALL run an independent 4-state FSM: REL (stable released), REL_CHK (released, candidate press), PRS (stable pressed), PRS_CHK (pressed, candidate release).
REQ-012 REL->REL_CHK when synced bit = 0; counter loads 1.
REQ-013 REL_CHK: synced = 0 and counter = DEBOUNCE_CYCLES-1 -> PRS; synced = 0 otherwise -> counter +1; synced = 1 -> REL, counter cleared (glitch rejected).
REQ-014 PRS->PRS_CHK when synced bit = 1; PRS_CHK mirrors REL_CHK with polarity inverted, accepting -> REL, rejecting -> PRS.
REQ-015 btn_clean bit SHALL be 0 exactly in PRS and PRS_CHK, 1 in REL and REL_CHK, registered.
REQ-016 Total latency raw edge to btn_clean change SHALL be 2 + DEBOUNCE_CYCLES clock cycles for a bounce-free input.
REQ-017 btn_press SHALL pulse in the same cycle btn_clean first reads 0 (REL_CHK->PRS registered); btn_release likewise on PRS_CHK->REL.
REQ-018 Any bounce shorter than DEBOUNCE_CYCLES SHALL produce no change on btn_clean, btn_press or btn_release.
REQ-019 Channels SHALL be fully independent; simultaneous accepted presses SHALL assert multiple btn_press bits in the same cycle.
REQ-020 Counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1 bits and SHALL never wrap; it is cleared on every state entry to REL or PRS.
REQ-021 multi_held SHALL be registered, derived from next-cycle btn_clean, asserting in the same cycle as btn_clean.

Reset
REQ-022 On rst: synchronizer flops = 1, all FSMs = REL, counters = 0, btn_clean = all-ones, btn_press = 0, btn_release = 0, multi_held = 0.
REQ-023 rst asserted mid-debounce SHALL abandon the candidate with no pulse emitted; a button held through reset SHALL be accepted as a fresh press 2 + DEBOUNCE_CYCLES cycles after rst deasserts.

Configuration
REQ-024 Macro BTN_COND_GLITCH_CNT_EN defined: adds output glitch_cnt [7:0], incremented once per rejected candidate (REQ-013/014 reject path), saturating at 255, cleared by rst; simultaneous rejections on several channels in one cycle add their count, still saturating.
REQ-025 Macro undefined: glitch_cnt port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-026 Package btn_cond_pkg SHALL hold the channel state enum (REL, REL_CHK, PRS, PRS_CHK) and DEBOUNCE_CYCLES_DEFAULT.
REQ-027 Sub-module btn_debounce_ch SHALL implement one channel (synchronizer, FSM, counter, pulses); btn_conditioner instantiates N_BTN copies plus multi_held and glitch_cnt logic.

Verification (DEBOUNCE_CYCLES = 8)
REQ-028 Clean press: btn_raw[0] 1->0 held 20 cycles -> btn_clean[0] = 0 exactly 10 cycles later, btn_press = 3'b001 for one cycle.
REQ-029 Bounce: btn_raw[1] toggles low 3 cycles / high 2 cycles four times, then high -> btn_clean stays 3'b111, no pulses, glitch_cnt = 4 when enabled.
REQ-030 Release: after accepted press on btn 2, raw returns to 1 -> btn_clean[2] = 1 after 10 cycles, btn_release = 3'b100 one cycle.
REQ-031 Simultaneous: btn_raw 3'b111 -> 3'b100 same cycle -> btn_press = 3'b011 in one cycle, multi_held = 1 same cycle as btn_clean = 3'b100.
REQ-032 Reset mid-operation: rst pulsed at counter = 5 with button held -> no btn_press during/after rst until 10 cycles post-deassert, then single pulse.
REQ-033 Saturation (macro on): 300 rejected glitches -> glitch_cnt = 255, no wrap.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg -- shared definitions for the push-button conditioner.
//   ch_state_e              : per-channel debounce state
//   DEBOUNCE_CYCLES_DEFAULT : default stable-cycle count (20 ms at 50 MHz)
package btn_cond_pkg;

  typedef enum logic [1:0] {
    REL     = 2'b00,  // stable released
    REL_CHK = 2'b01,  // released, candidate press being timed
    PRS     = 2'b10,  // stable pressed
    PRS_CHK = 2'b11   // pressed, candidate release being timed
  } ch_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch -- one push-button channel: 2-flop synchronizer,
// 4-state debounce FSM with a stable-cycle counter, press/release pulses.
// Optional feature macro: BTN_COND_GLITCH_CNT_EN (adds the reject output).
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   btn_raw      : asynchronous active-low button
//   btn_clean    : registered debounced level, active-low
//   btn_press    : one-cycle pulse when a press is accepted
//   btn_release  : one-cycle pulse when a release is accepted
//   clean_next   : value btn_clean takes at the next edge (for multi_held)
//   reject       : (macro only) candidate rejected at this edge
module btn_debounce_ch
  import btn_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean,
  output logic btn_press,
  output logic btn_release,
  output logic clean_next
`ifdef BTN_COND_GLITCH_CNT_EN
  ,
  output logic reject
`endif
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  // The counter stops at DEBOUNCE_CYCLES-1, so CNT_W bits never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, press_q, release_q;
  logic             press_d, release_d;

  // Next-state, counter and pulse decode for the debounce FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      REL: begin
        if (!sync2_q) begin
          state_d = REL_CHK;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      REL_CHK: begin
        if (sync2_q) begin
          state_d = REL;                  // glitch rejected
          cnt_d   = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS;
          cnt_d   = {CNT_W{1'b0}};
          press_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      PRS: begin
        if (sync2_q) begin
          state_d = PRS_CHK;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d   = {CNT_W{1'b0}};
        end
      end
      PRS_CHK: begin
        if (!sync2_q) begin
          state_d   = PRS;                // glitch rejected
          cnt_d     = {CNT_W{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          state_d   = REL;
          cnt_d     = {CNT_W{1'b0}};
          release_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Level is pressed exactly in PRS/PRS_CHK; reset forces released.
  always_comb begin
    if (rst) begin
      clean_next = 1'b1;
    end else begin
      clean_next = !((state_d == PRS) || (state_d == PRS_CHK));
    end
  end

  // Synchronizer, FSM state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= REL;
      cnt_q     <= {CNT_W{1'b0}};
      clean_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_next;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_clean   = clean_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BTN_COND_GLITCH_CNT_EN
  // A candidate is rejected when the synced level returns before acceptance.
  assign reject = !rst && (((state_q == REL_CHK) && sync2_q) ||
                           ((state_q == PRS_CHK) && !sync2_q));
`endif

endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner -- N_BTN independent debounced push-button channels.
// Optional feature macro: BTN_COND_GLITCH_CNT_EN (adds glitch_cnt output).
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   btn_raw      : asynchronous active-low buttons
//   btn_clean    : debounced levels, active-low
//   btn_press    : one-cycle pulse per accepted press
//   btn_release  : one-cycle pulse per accepted release
//   multi_held   : more than one btn_clean bit low
//   glitch_cnt   : (macro only) saturating count of rejected candidates
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned N_BTN           = 32'd3,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             multi_held
`ifdef BTN_COND_GLITCH_CNT_EN
  ,
  output logic [7:0]       glitch_cnt
`endif
);

  logic [N_BTN-1:0] clean_next;
  logic             multi_held_q, multi_held_d;
`ifdef BTN_COND_GLITCH_CNT_EN
  logic [N_BTN-1:0] reject;
  logic [7:0]       glitch_cnt_q, glitch_cnt_d;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw[i]),
      .btn_clean   (btn_clean[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .clean_next  (clean_next[i])
`ifdef BTN_COND_GLITCH_CNT_EN
      ,
      .reject      (reject[i])
`endif
    );
  end

  // Count buttons held in the next cycle so multi_held aligns with btn_clean.
  always_comb begin
    int unsigned held;
    held = 32'd0;
    for (int i = 0; i < N_BTN; i++) begin
      held = held + 32'(!clean_next[i]);
    end
    if (rst) begin
      multi_held_d = 1'b0;
    end else begin
      multi_held_d = (held > 32'd1);
    end
  end

`ifdef BTN_COND_GLITCH_CNT_EN
  // Add this cycle's rejections from all channels, saturating at 255.
  always_comb begin
    int unsigned sum;
    sum = 32'(glitch_cnt_q);
    for (int i = 0; i < N_BTN; i++) begin
      sum = sum + 32'(reject[i]);
    end
    if (rst) begin
      glitch_cnt_d = 8'd0;
    end else if (sum > 32'd255) begin
      glitch_cnt_d = 8'd255;
    end else begin
      glitch_cnt_d = sum[7:0];
    end
  end

  // Glitch counter register.
  always_ff @(posedge clk) begin
    glitch_cnt_q <= glitch_cnt_d;
  end

  assign glitch_cnt = glitch_cnt_q;
`endif

  // multi_held register.
  always_ff @(posedge clk) begin
    multi_held_q <= multi_held_d;
  end

  assign multi_held = multi_held_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner -- self-checking bench for btn_conditioner with
// N_BTN = 3, DEBOUNCE_CYCLES = 8. Works with or without BTN_COND_GLITCH_CNT_EN.
module tb_btn_conditioner;

  localparam int N = 3;
  localparam int D = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_clean, btn_press, btn_release;
  logic         multi_held;
`ifdef BTN_COND_GLITCH_CNT_EN
  logic [7:0]   glitch_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_clean   (btn_clean),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .multi_held  (multi_held)
`ifdef BTN_COND_GLITCH_CNT_EN
    ,
    .glitch_cnt  (glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: two-sample delay line, then a per-channel run length of
  // samples that disagree with the accepted level; D disagreeing samples in
  // a row flip the level, an agreeing sample during a run is a glitch.
  logic [N-1:0] m_p1, m_p2, m_clean, m_press, m_rel;
  logic         m_multi;
  int           m_run [N];
  int           m_glitch;

  function automatic logic [17:0] obs_vec();
    logic [7:0] g;
`ifdef BTN_COND_GLITCH_CNT_EN
    g = glitch_cnt;
`else
    g = 8'd0;
`endif
    return {btn_clean, btn_press, btn_release, multi_held, g};
  endfunction

  function automatic logic [17:0] exp_vec();
    logic [7:0] g;
`ifdef BTN_COND_GLITCH_CNT_EN
    g = 8'(m_glitch);
`else
    g = 8'd0;
`endif
    return {m_clean, m_press, m_rel, m_multi, g};
  endfunction

  // Advance one clock and update the model with the inputs seen at the edge.
  task automatic tick();
    logic [N-1:0] r;
    logic         rs;
    r  = btn_raw;
    rs = rst;
    @(posedge clk);
    #1;
    m_press = '0;
    m_rel   = '0;
    if (rs) begin
      m_p1 = '1; m_p2 = '1; m_clean = '1; m_multi = 1'b0; m_glitch = 0;
      for (int c = 0; c < N; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (m_p2[c] != m_clean[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_clean[c] = m_p2[c];
            if (m_p2[c] == 1'b0) m_press[c] = 1'b1;
            else                 m_rel[c]   = 1'b1;
            m_run[c] = 0;
          end
        end else begin
          if (m_run[c] > 0 && m_glitch < 255) m_glitch++;
          m_run[c] = 0;
        end
      end
      m_p2 = m_p1;
      m_p1 = r;
      m_multi = ($countones(~m_clean) > 1);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    btn_raw = 3'b111;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_model cyc=%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    n_vec++;
    if ({btn_clean, btn_press, btn_release, multi_held} !== {3'b111, 3'b000, 3'b000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values got clean=%b press=%b rel=%b multi=%b", btn_clean, btn_press, btn_release, multi_held);
    end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int lat;
    logic [N-1:0] p_at;
    apply_reset();
    btn_raw = 3'b111;
    repeat (3) tick();
    btn_raw = 3'b110;
    lat = -1;
    p_at = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL clean_press_model cyc=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (lat < 0 && btn_clean[0] == 1'b0) begin
        lat = c;
        p_at = btn_press;
      end
    end
    n_vec++;
    if (lat != 10 || p_at !== 3'b001) begin
      n_err++;
      $display("FAIL clean_press_latency got lat=%0d press=%b want lat=10 press=001", lat, p_at);
    end
    btn_raw = 3'b111;
    for (int c = 0; c < 14; c++) begin
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL clean_press_tail cyc=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_bounce();
    logic bad;
    apply_reset();
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 5; c++) begin
        btn_raw = (c < 3) ? 3'b101 : 3'b111;
        tick();
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
          n_err++;
          $display("FAIL bounce_model k=%0d c=%0d got %h want %h", k, c, obs_vec(), exp_vec());
        end
        if (btn_clean !== 3'b111 || btn_press !== 3'b000 || btn_release !== 3'b000) bad = 1'b1;
      end
    end
    btn_raw = 3'b111;
    for (int c = 0; c < 15; c++) begin
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL bounce_tail c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (btn_clean !== 3'b111 || btn_press !== 3'b000 || btn_release !== 3'b000) bad = 1'b1;
    end
    n_vec++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_outputs_moved got 1 want 0");
    end
`ifdef BTN_COND_GLITCH_CNT_EN
    n_vec++;
    if (glitch_cnt !== 8'd4) begin
      n_err++;
      $display("FAIL bounce_glitch_cnt got %0d want 4", glitch_cnt);
    end
`endif
  endtask

  task automatic test_release();
    int lat;
    logic [N-1:0] r_at;
    apply_reset();
    btn_raw = 3'b011;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL release_hold c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    btn_raw = 3'b111;
    lat = -1;
    r_at = '0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL release_model c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (lat < 0 && btn_clean[2] == 1'b1) begin
        lat = c;
        r_at = btn_release;
      end
    end
    n_vec++;
    if (lat != 10 || r_at !== 3'b100) begin
      n_err++;
      $display("FAIL release_latency got lat=%0d rel=%b want lat=10 rel=100", lat, r_at);
    end
  endtask

  task automatic test_simultaneous();
    int lat;
    logic [N-1:0] p_at;
    logic m_at, m_before, prev_m;
    apply_reset();
    btn_raw = 3'b100;
    lat = -1; p_at = '0; m_at = 1'b0; m_before = 1'b1; prev_m = multi_held;
    for (int c = 1; c <= 15; c++) begin
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL simul_model c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (lat < 0 && btn_clean == 3'b100) begin
        lat = c; p_at = btn_press; m_at = multi_held; m_before = prev_m;
      end
      prev_m = multi_held;
    end
    n_vec++;
    if (lat != 10 || p_at !== 3'b011 || m_at !== 1'b1 || m_before !== 1'b0) begin
      n_err++;
      $display("FAIL simul_press got lat=%0d press=%b multi=%b pre=%b want 10 011 1 0", lat, p_at, m_at, m_before);
    end
    btn_raw = 3'b111;
    repeat (14) tick();
  endtask

  task automatic test_reset_mid();
    int npress, first;
    logic early;
    apply_reset();
    btn_raw = 3'b110;
    early = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rstmid_pre c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (btn_press !== 3'b000) early = 1'b1;
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (btn_press !== 3'b000) early = 1'b1;
    end
    rst = 1'b0;
    npress = 0; first = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL rstmid_post c=%0d got %h want %h", c, obs_vec(), exp_vec());
      end
      if (btn_press[0] === 1'b1) begin
        npress++;
        if (first < 0) first = c;
      end
    end
    n_vec++;
    if (early !== 1'b0 || npress != 1 || first != 10) begin
      n_err++;
      $display("FAIL rstmid_press got early=%b n=%0d at=%0d want 0 1 10", early, npress, first);
    end
    btn_raw = 3'b111;
    repeat (14) tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      btn_raw = 3'b110;
      tick();
      btn_raw = 3'b111;
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL sat_model k=%0d got %h want %h", k, obs_vec(), exp_vec());
      end
    end
    repeat (4) tick();
`ifdef BTN_COND_GLITCH_CNT_EN
    n_vec++;
    if (glitch_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL sat_glitch_cnt got %0d want 255", glitch_cnt);
    end
`endif
    n_vec++;
    if (btn_clean !== 3'b111) begin
      n_err++;
      $display("FAIL sat_clean got %b want 111", btn_clean);
    end
  endtask

  task automatic test_random();
    int hold [N];
    apply_reset();
    btn_raw = 3'b111;
    for (int c = 0; c < N; c++) hold[c] = int'($urandom_range(1, 14));
    for (int t = 0; t < 2500; t++) begin
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          btn_raw[c] = ~btn_raw[c];
          hold[c] = int'($urandom_range(1, 14));
        end
      end
      rst = (t == 1200 || t == 1201) ? 1'b1 : 1'b0;
      tick();
      n_vec++;
      if (obs_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random_model t=%0d got %h want %h", t, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn_raw = 3'b111;
    m_p1 = '1; m_p2 = '1; m_clean = '1; m_press = '0; m_rel = '0;
    m_multi = 1'b0; m_glitch = 0;
    for (int c = 0; c < N; c++) m_run[c] = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
